// File: rtl/nn_ctrl_pkg.sv
// Shared types and phase-code constants for the neuron layer training controller.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_F_SETUP = 3'd1,
    ST_F_RUN   = 3'd2,
    ST_B_SETUP = 3'd3,
    ST_B_RUN   = 3'd4,
    ST_COMMIT  = 3'd5,
    ST_I_CAPT  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [1:0] PH_FSETUP = 2'b00;
  localparam logic [1:0] PH_FPROP  = 2'b10;
  localparam logic [1:0] PH_BSETUP = 2'b11;
  localparam logic [1:0] PH_BPROP  = 2'b01;

  // {fp,bp} presented to the neurons while the sequencer sits in a given state.
  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] ph;
    case (s)
      ST_F_RUN:   ph = PH_FPROP;
      ST_B_SETUP: ph = PH_BSETUP;
      ST_B_RUN:   ph = PH_BPROP;
      default:    ph = PH_FSETUP;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing the F_RUN and B_RUN phases; o_zero marks the last cycle.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/neuron_train_sequencer.sv
// Sequences a neuron layer through forward/backward/commit phases per sample,
// tracking sample/epoch indices and the per-epoch correct-prediction tally.
module neuron_train_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int N         = 30,
  parameter int FP_CYCLES = N / 2 + 5,
  parameter int BP_CYCLES = N + 4,
  parameter int SAMPLE_W  = 10,
  parameter int EPOCH_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                train_en,
  input  logic [SAMPLE_W-1:0] num_samples,
  input  logic [EPOCH_W-1:0]  num_epochs,
  input  logic                yhat_bit,
  input  logic                label_bit,
  output logic                fp,
  output logic                bp,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic [EPOCH_W-1:0]  epoch_idx,
  output logic                y_vld,
  output logic                w_we,
  output logic                epoch_vld,
  output logic [SAMPLE_W-1:0] epoch_correct,
  output logic                busy,
  output logic                done
);

  localparam int PC_MAX = (FP_CYCLES > BP_CYCLES) ? FP_CYCLES : BP_CYCLES;
  localparam int CNT_W  = $clog2(PC_MAX + 1);
  localparam logic [CNT_W-1:0] FP_LOAD = CNT_W'(FP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BP_LOAD = CNT_W'(BP_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic                r_train_en;
  logic [SAMPLE_W-1:0] r_num_samples;
  logic [EPOCH_W-1:0]  r_num_epochs;
  logic [SAMPLE_W-1:0] r_sample_idx;
  logic [EPOCH_W-1:0]  r_epoch_idx;
  logic [SAMPLE_W-1:0] r_tally;
  logic [SAMPLE_W-1:0] r_epoch_correct;
  logic                r_fp, r_bp, r_y_vld, r_w_we, r_epoch_vld, r_busy, r_done;

  logic [SAMPLE_W-1:0] w_sample_inc;
  logic [EPOCH_W-1:0]  w_epoch_inc;
  logic                w_last_sample, w_last_epoch;
  logic                w_cfg_ok, w_start_go;
  logic                w_sample_end, w_epoch_end;
  logic                w_match;
  logic [SAMPLE_W-1:0] w_tally_nxt;
  logic [1:0]          w_ph;
  logic                w_pc_load, w_pc_dec, w_pc_zero;
  logic [CNT_W-1:0]    w_pc_val;

  assign w_sample_inc  = r_sample_idx + {{(SAMPLE_W-1){1'b0}}, 1'b1};
  assign w_epoch_inc   = r_epoch_idx + {{(EPOCH_W-1){1'b0}}, 1'b1};
  assign w_last_sample = (w_sample_inc == r_num_samples);
  assign w_last_epoch  = (w_epoch_inc == r_num_epochs);
  assign w_cfg_ok      = (num_samples != {SAMPLE_W{1'b0}}) && (num_epochs != {EPOCH_W{1'b0}});
  assign w_start_go    = (r_state == ST_IDLE) && start && !abort && w_cfg_ok;
  assign w_sample_end  = ((r_state == ST_COMMIT) || (r_state == ST_I_CAPT)) && !abort;
  assign w_epoch_end   = w_sample_end && w_last_sample;

  // Tally saturates rather than wrapping so a long epoch never reports a small count.
  assign w_match     = r_y_vld && (yhat_bit == label_bit) && !abort;
  assign w_tally_nxt = (w_match && (r_tally != {SAMPLE_W{1'b1}}))
                     ? (r_tally + {{(SAMPLE_W-1){1'b0}}, 1'b1}) : r_tally;

  assign w_pc_load = (r_state == ST_F_SETUP) || (r_state == ST_B_SETUP);
  assign w_pc_val  = (r_state == ST_B_SETUP) ? BP_LOAD : FP_LOAD;
  assign w_pc_dec  = (r_state == ST_F_RUN) || (r_state == ST_B_RUN);

  phase_counter #(.W(CNT_W)) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_val),
    .i_dec      (w_pc_dec),
    .o_zero     (w_pc_zero)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = w_cfg_ok ? ST_F_SETUP : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_F_SETUP: w_next = ST_F_RUN;
      ST_F_RUN: begin
        if (w_pc_zero) begin
          w_next = r_train_en ? ST_B_SETUP : ST_I_CAPT;
        end else begin
          w_next = ST_F_RUN;
        end
      end
      ST_B_SETUP: w_next = ST_B_RUN;
      ST_B_RUN: begin
        if (w_pc_zero) begin
          w_next = ST_COMMIT;
        end else begin
          w_next = ST_B_RUN;
        end
      end
      ST_COMMIT, ST_I_CAPT: begin
        if (w_last_sample && w_last_epoch) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_F_SETUP;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      w_next = w_next;
    end
  end

  assign w_ph = phase_of(w_next);

  // State register and Moore outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fp        <= 1'b0;
      r_bp        <= 1'b0;
      r_y_vld     <= 1'b0;
      r_w_we      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_epoch_vld <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fp        <= w_ph[1];
      r_bp        <= w_ph[0];
      r_y_vld     <= (w_next == ST_B_SETUP) || (w_next == ST_I_CAPT);
      r_w_we      <= (w_next == ST_COMMIT);
      r_done      <= (w_next == ST_DONE);
      r_busy      <= (w_next != ST_IDLE);
      r_epoch_vld <= w_epoch_end;
    end
  end

  // Config latch, sample/epoch indices and the correct-prediction tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_train_en      <= 1'b0;
      r_num_samples   <= {SAMPLE_W{1'b0}};
      r_num_epochs    <= {EPOCH_W{1'b0}};
      r_sample_idx    <= {SAMPLE_W{1'b0}};
      r_epoch_idx     <= {EPOCH_W{1'b0}};
      r_tally         <= {SAMPLE_W{1'b0}};
      r_epoch_correct <= {SAMPLE_W{1'b0}};
    end else if (w_start_go) begin
      r_train_en    <= train_en;
      r_num_samples <= num_samples;
      r_num_epochs  <= num_epochs;
      r_sample_idx  <= {SAMPLE_W{1'b0}};
      r_epoch_idx   <= {EPOCH_W{1'b0}};
      r_tally       <= {SAMPLE_W{1'b0}};
    end else if (w_epoch_end) begin
      r_epoch_correct <= w_tally_nxt;
      r_tally         <= {SAMPLE_W{1'b0}};
      if (!w_last_epoch) begin
        r_sample_idx <= {SAMPLE_W{1'b0}};
        r_epoch_idx  <= w_epoch_inc;
      end else begin
        r_sample_idx <= r_sample_idx;
        r_epoch_idx  <= r_epoch_idx;
      end
    end else if (w_sample_end) begin
      r_sample_idx <= w_sample_inc;
      r_tally      <= w_tally_nxt;
    end else begin
      r_tally <= w_tally_nxt;
    end
  end

  assign fp            = r_fp;
  assign bp            = r_bp;
  assign sample_idx    = r_sample_idx;
  assign epoch_idx     = r_epoch_idx;
  assign y_vld         = r_y_vld;
  assign w_we          = r_w_we;
  assign epoch_vld     = r_epoch_vld;
  assign epoch_correct = r_epoch_correct;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: doc/neuron_train_sequencer.md
# neuron_train_sequencer

Drives the `{FP,BP}` phase code of a neuron layer through a training or inference schedule. Each sample runs in the order forward setup, forward propagation, backward setup, backward propagation, then weight commit. The block keeps sample and epoch counters, issues the sample-fetch index and capture strobes, and tallies correct predictions per epoch. It sits between the top-level training control and the neuron array; all neurons in a layer share its `fp`/`bp` outputs.

## Interface
Parameters:
- `N`, 30: neuron fan-in; used only for default cycle counts.
- `FP_CYCLES`, 20: forward-propagation phase length in cycles (N/2 issue + adder/activation pipeline), ≥1.
- `BP_CYCLES`, 34: backward-propagation phase length in cycles (N issue + 3 write-back lag + 1), ≥1.
- `SAMPLE_W`, 10: sample counter width.
- `EPOCH_W`, 8: epoch counter width.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: level; sampled only in IDLE.
- `abort` in 1: synchronous abort; wins over every other input.
- `train_en` in 1: 1 selects training, 0 selects inference (no backward phase). Latched at start.
- `num_samples` in SAMPLE_W: samples per epoch. Latched at start.
- `num_epochs` in EPOCH_W: epoch count. Latched at start.
- `yhat_bit` in 1: predicted class from the neuron (`yhat != 0`).
- `label_bit` in 1: true class of the current sample.
- `fp`, `bp` out 1 each: phase code to the neurons.
- `sample_idx` out SAMPLE_W: index of the current sample for x/y_true fetch.
- `epoch_idx` out EPOCH_W: current epoch.
- `y_vld` out 1: one-cycle strobe; neuron output is valid.
- `w_we` out 1: one-cycle strobe; capture `W_out` into the weight store.
- `epoch_vld` out 1: one-cycle strobe at epoch end.
- `epoch_correct` out SAMPLE_W: correct-prediction count for the finished epoch.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle strobe when the run completes.

## Operation
- **States and phase codes:**
  - IDLE: 00
  - F_SETUP: 00
  - F_RUN: 10
  - B_SETUP: 11
  - B_RUN: 01
  - COMMIT: 00
  - I_CAPT: 00
  - DONE: 00
- The idle code 00 is the neuron's forward setup. This is idempotent and harmless.
- **IDLE:**
  - On `start=1` with `num_samples≠0` and `num_epochs≠0`: latch the config, clear the indices and tally, go to F_SETUP.
  - On `start=1` with either count zero: go to DONE.
- **F_SETUP:** 1 cycle, then F_RUN.
- **F_RUN:** FP_CYCLES cycles, using a phase down-counter. Then go to B_SETUP if `train_en`, else I_CAPT.
- **B_SETUP:** 1 cycle. `y_vld=1`. Then B_RUN.
- **B_RUN:** BP_CYCLES cycles, then COMMIT.
- **COMMIT:** 1 cycle. `w_we=1`.
- **I_CAPT:** 1 cycle. `y_vld=1`.
- **After COMMIT or I_CAPT:**
  - If `sample_idx` is not the last sample: increment `sample_idx`, go to F_SETUP.
  - Else, at the last sample of a non-last epoch: pulse `epoch_vld`, set `sample_idx=0`, increment `epoch_idx`, clear the tally, go to F_SETUP.
  - Else, at the last sample of the last epoch: pulse `epoch_vld`, go to DONE.
- **DONE:** `done=1` for 1 cycle, then IDLE. `sample_idx` and `epoch_idx` hold their final values until the next start.
- **Tally:**
  - Increment when `y_vld && (yhat_bit==label_bit)`.
  - `epoch_correct` registers the tally including the current sample's result, and is updated in the same cycle `epoch_vld` rises.
  - The tally saturates at all-ones.
- **Abort:** next state is IDLE and `fp=bp=0`. No `w_we`, `done` or `epoch_vld` is produced in the abort cycle or after it. Counters hold their values.
- **Reset:** all outputs 0, state IDLE.

## Timing
- All outputs are registered Moore outputs decoded from state. `fp`/`bp` change on the clock edge that enters the state.
- `busy` rises 1 cycle after `start` is sampled.
- Cycles per sample:
  - Train: FP_CYCLES+BP_CYCLES+3. This is 57 at default parameters.
  - Inference: FP_CYCLES+2. This is 22 at default parameters.
- Total run in train mode: `num_epochs×num_samples×(FP+BP+3)` cycles from the first F_SETUP, then 1 DONE cycle.
- `sample_idx` is stable from F_SETUP through COMMIT/I_CAPT. The fetch path must present x/y_true by the first F_SETUP cycle.
- `start` is ignored while `busy`. Config ports may change freely once latched.

## Structure
- Package `nn_ctrl_pkg` holds:
  - the `state_t` enum;
  - phase-code constants `PH_FSETUP=2'b00`, `PH_FPROP=2'b10`, `PH_BSETUP=2'b11`, `PH_BPROP=2'b01`.
- One sub-module, `phase_counter`: loadable down-counter with a `zero` flag, shared by F_RUN and B_RUN.

## Test plan
- Reset mid-F_RUN, with `rst_n` low asynchronously → all outputs 0 immediately. After release, IDLE with `busy=0`.
- Train, `num_samples=2`, `num_epochs=1`, defaults → phase sequence 00,10×20,11,01×34,00 for each sample:
  - `w_we` at cycles 57 and 114;
  - `epoch_vld` and `done` on schedule;
  - `busy` high for 115 cycles.
- Inference, `num_samples=3`, `num_epochs=2` → no 11/01 codes, no `w_we`, six `y_vld` pulses, `epoch_idx` 0→1, `done` after 133 cycles.
- Tally: labels match on samples 0 and 2 of 3 → `epoch_correct=2` with `epoch_vld`; tally is 0 again at the first `y_vld` of the next epoch.
- `abort` during B_RUN of sample 1 → IDLE next cycle; no `w_we`, no `done`.
- `num_samples=0` with `start` → single `done` pulse with `fp=bp=0` throughout, no `y_vld`.
